// File: rtl/systolic_array_ctrl_pkg.sv
// rtl/systolic_array_ctrl_pkg.sv - shared types and default sizes for the systolic array sequencer
package systolic_array_ctrl_pkg;

  localparam int DEF_BITS_AB = 8;
  localparam int DEF_BITS_C  = 16;
  localparam int DEF_DIM     = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    READ,
    FIN
  } sa_state_e;

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// rtl/systolic_array_ctrl_if.sv - host control, operand buffer and C row stream bundle
interface systolic_array_ctrl_if
  import systolic_array_ctrl_pkg::*;
#(
  parameter int DIM     = DEF_DIM,
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C
);
  localparam int ROWBITS = $clog2(DIM);

  logic                    start;
  logic                    acc;
  logic                    busy;
  logic                    done;
  logic                    ab_rd;
  logic [ROWBITS-1:0]      ab_addr;
  logic [DIM*BITS_AB-1:0]  a_rd_data;
  logic [DIM*BITS_AB-1:0]  b_rd_data;
  logic                    c_valid;
  logic                    c_ready;
  logic [ROWBITS-1:0]      c_row;
  logic [DIM*BITS_C-1:0]   c_data;

  modport slave (
    input  start, acc, a_rd_data, b_rd_data, c_ready,
    output busy, done, ab_rd, ab_addr, c_valid, c_row, c_data
  );

  modport master (
    output start, acc, a_rd_data, b_rd_data, c_ready,
    input  busy, done, ab_rd, ab_addr, c_valid, c_row, c_data
  );

endinterface

// File: rtl/systolic_array_ctrl_skew.sv
// rtl/systolic_array_ctrl_skew.sv - triangular delay line: lane i delays its slice by i cycles
module systolic_skew
  import systolic_array_ctrl_pkg::*;
#(
  parameter int W   = DEF_BITS_AB,
  parameter int DIM = DEF_DIM
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  input  logic [DIM*W-1:0]        in_data_i,
  output logic [DIM-1:0][W-1:0]   out_data_o
);

  // Invalid read data is replaced by zeros so the array edge only ever sees operands or zeros.
  logic [DIM*W-1:0] gated;
  assign gated = in_valid_i ? in_data_i : '0;

  assign out_data_o[0] = gated[W-1:0];

  for (genvar i = 1; i < DIM; i++) begin : g_lane
    logic [W-1:0] sh_q [i];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < i; j++) sh_q[j] <= '0;
      end else begin
        sh_q[0] <= gated[i*W +: W];
        for (int j = 1; j < i; j++) sh_q[j] <= sh_q[j-1];
      end
    end

    assign out_data_o[i] = sh_q[i-1];
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - clear / feed / read-out sequencer for one systolic array
module systolic_array_ctrl
  import systolic_array_ctrl_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C,
  parameter int DIM     = DEF_DIM
) (
  input  logic                          clk,
  input  logic                          rst,
  systolic_array_ctrl_if.slave          bus,
  output logic                          sa_en_o,
  output logic                          sa_WrEn_o,
  output logic [$clog2(DIM)-1:0]        sa_Crow_o,
  output logic [DIM-1:0][BITS_AB-1:0]   sa_A_o,
  output logic [DIM-1:0][BITS_AB-1:0]   sa_B_o,
  output logic [DIM-1:0][BITS_C-1:0]    sa_Cin_o,
  input  logic [DIM-1:0][BITS_C-1:0]    sa_Cout_i
);

  localparam int ROWBITS = $clog2(DIM);
  localparam int CNTW    = $clog2(3*DIM);

  localparam logic [CNTW-1:0]    CLR_LAST  = CNTW'(DIM - 1);
  localparam logic [CNTW-1:0]    RD_END    = CNTW'(DIM);
  localparam logic [CNTW-1:0]    FEED_LAST = CNTW'(3*DIM - 2);
  localparam logic [ROWBITS-1:0] ROW_LAST  = ROWBITS'(DIM - 1);

  sa_state_e              state_q;
  logic [CNTW-1:0]        cnt_q;
  logic [CNTW-1:0]        cnt_inc;
  logic                   busy_q;
  logic                   done_q;
  logic                   ab_rd_q;
  logic [ROWBITS-1:0]     ab_addr_q;
  logic                   rd_vld_q;
  logic                   sa_en_q;
  logic                   wr_en_q;
  logic [ROWBITS-1:0]     crow_q;
  logic                   issued_q;
  logic                   c_valid_q;
  logic [ROWBITS-1:0]     c_row_q;
  logic [DIM*BITS_C-1:0]  c_data_q;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ab_rd_q   <= 1'b0;
      ab_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      sa_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      crow_q    <= '0;
      issued_q  <= 1'b0;
      c_valid_q <= 1'b0;
      c_row_q   <= '0;
      c_data_q  <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_vld_q <= ab_rd_q;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (bus.acc) begin
              state_q   <= FEED;
              ab_rd_q   <= 1'b1;
              ab_addr_q <= '0;
            end else begin
              state_q <= CLR;
              wr_en_q <= 1'b1;
              crow_q  <= '0;
            end
          end
        end
        CLR: begin
          if (cnt_q == CLR_LAST) begin
            state_q   <= FEED;
            wr_en_q   <= 1'b0;
            crow_q    <= '0;
            cnt_q     <= '0;
            ab_rd_q   <= 1'b1;
            ab_addr_q <= '0;
          end else begin
            cnt_q  <= cnt_inc;
            crow_q <= cnt_inc[ROWBITS-1:0];
          end
        end
        FEED: begin
          // Outputs are computed one cycle ahead so they line up with cnt_q.
          ab_rd_q   <= (cnt_inc < RD_END);
          ab_addr_q <= (cnt_inc < RD_END) ? cnt_inc[ROWBITS-1:0] : '0;
          sa_en_q   <= (cnt_q != FEED_LAST);
          if (cnt_q == FEED_LAST) begin
            state_q  <= READ;
            cnt_q    <= '0;
            crow_q   <= '0;
            issued_q <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        READ: begin
          // One row in flight: a new row is captured whenever the output slot is empty or draining.
          if (c_valid_q && bus.c_ready && c_row_q == ROW_LAST) begin
            state_q   <= FIN;
            c_valid_q <= 1'b0;
            done_q    <= 1'b1;
          end else if ((!c_valid_q || bus.c_ready) && !issued_q) begin
            c_data_q  <= sa_Cout_i;
            c_row_q   <= crow_q;
            c_valid_q <= 1'b1;
            if (crow_q == ROW_LAST) issued_q <= 1'b1;
            else                    crow_q   <= crow_q + 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          crow_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  systolic_skew #(.W(BITS_AB), .DIM(DIM)) u_skew_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (rd_vld_q),
    .in_data_i  (bus.a_rd_data),
    .out_data_o (sa_A_o)
  );

  systolic_skew #(.W(BITS_AB), .DIM(DIM)) u_skew_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (rd_vld_q),
    .in_data_i  (bus.b_rd_data),
    .out_data_o (sa_B_o)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ab_rd   = ab_rd_q;
  assign bus.ab_addr = ab_addr_q;
  assign bus.c_valid = c_valid_q;
  assign bus.c_row   = c_row_q;
  assign bus.c_data  = c_data_q;

  assign sa_en_o   = sa_en_q;
  assign sa_WrEn_o = wr_en_q;
  assign sa_Crow_o = crow_q;
  assign sa_Cin_o  = '0;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb/tb_systolic_array_ctrl.sv - directed bench with operand buffer and systolic array models
module tb_systolic_array_ctrl;

  localparam int DIM     = 8;
  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int ROWBITS = $clog2(DIM);

  logic clk;
  logic rst;
  logic                          sa_en;
  logic                          sa_wren;
  logic [ROWBITS-1:0]            sa_crow;
  logic [DIM-1:0][BITS_AB-1:0]   sa_a;
  logic [DIM-1:0][BITS_AB-1:0]   sa_b;
  logic [DIM-1:0][BITS_C-1:0]    sa_cin;
  logic [DIM-1:0][BITS_C-1:0]    sa_cout;

  int total_cnt = 0;
  int bad_cnt   = 0;

  int a_m [DIM][DIM];
  int b_m [DIM][DIM];

  systolic_array_ctrl_if #(.DIM(DIM), .BITS_AB(BITS_AB), .BITS_C(BITS_C)) bus ();

  systolic_array_ctrl #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sa_en_o   (sa_en),
    .sa_WrEn_o (sa_wren),
    .sa_Crow_o (sa_crow),
    .sa_A_o    (sa_a),
    .sa_B_o    (sa_b),
    .sa_Cin_o  (sa_cin),
    .sa_Cout_i (sa_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand buffer: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.ab_rd) begin
      for (int i = 0; i < DIM; i++) begin
        bus.a_rd_data[i*BITS_AB +: BITS_AB] <= BITS_AB'(a_m[i][bus.ab_addr]);
        bus.b_rd_data[i*BITS_AB +: BITS_AB] <= BITS_AB'(b_m[bus.ab_addr][i]);
      end
    end
  end

  // Output-stationary array: A moves right, B moves down, each PE accumulates a*b.
  logic signed [BITS_C-1:0]  c_m  [DIM][DIM];
  logic signed [BITS_AB-1:0] a_r  [DIM][DIM];
  logic signed [BITS_AB-1:0] b_r  [DIM][DIM];
  logic signed [BITS_AB-1:0] a_in [DIM][DIM];
  logic signed [BITS_AB-1:0] b_in [DIM][DIM];

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      a_in[i][0] = sa_a[i];
      b_in[0][i] = sa_b[i];
      for (int j = 1; j < DIM; j++) begin
        a_in[i][j] = a_r[i][j-1];
        b_in[j][i] = b_r[j-1][i];
      end
    end
    for (int j = 0; j < DIM; j++) sa_cout[j] = c_m[sa_crow][j];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          a_r[i][j] <= '0;
          b_r[i][j] <= '0;
          c_m[i][j] <= '0;
        end
    end else begin
      if (sa_wren)
        for (int j = 0; j < DIM; j++) c_m[sa_crow][j] <= sa_cin[j];
      if (sa_en)
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++) begin
            c_m[i][j] <= c_m[i][j] + a_in[i][j] * b_in[i][j];
            a_r[i][j] <= a_in[i][j];
            b_r[i][j] <= b_in[i][j];
          end
    end
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_mats(input int kind);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        case (kind)
          0: begin a_m[i][j] = (i == j) ? 1 : 0; b_m[i][j] = i + j; end
          1: begin a_m[i][j] = 2;                b_m[i][j] = -3;    end
          2: begin a_m[i][j] = 127;              b_m[i][j] = -128;  end
          default: begin a_m[i][j] = 16*i + j;   b_m[i][j] = 0;     end
        endcase
      end
  endtask

  task automatic run_op(input logic acc_v, input int mode, input logic chk_data,
                        input logic use_sum, input int exp_v, input logic poke);
    int fbase, fc, k, ea, eb, nwr, nen, ndone, nrow, st3, done_cyc;
    logic stalled;
    logic [ROWBITS-1:0] prow;
    logic [DIM*BITS_C-1:0] pdata;
    logic signed [BITS_C-1:0] lane;
    nwr = 0; nen = 0; ndone = 0; nrow = 0; st3 = 0; done_cyc = -1; stalled = 1'b0;
    prow = '0; pdata = '0;
    @(negedge clk);
    bus.acc     = acc_v;
    bus.start   = 1'b1;
    bus.c_ready = (mode == 0);
    @(negedge clk);
    bus.start = 1'b0;
    fbase = acc_v ? 0 : DIM;
    for (int cyc = 0; cyc < 400; cyc++) begin
      fc = cyc - fbase;
      if (bus.done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk_eq("done_after_last_row", nrow, DIM);
        end
      end
      if (sa_wren) nwr++;
      if (sa_en) nen++;
      if (!acc_v && cyc < DIM) chk_eq("clr_crow", int'(sa_crow), cyc);
      if (fc >= 0 && fc <= 3*DIM - 1) begin
        chk_eq("feed_en", int'(sa_en), (fc >= 1 && fc <= 3*DIM - 2) ? 1 : 0);
        chk_eq("feed_rd", int'(bus.ab_rd), (fc < DIM) ? 1 : 0);
        if (fc < DIM) chk_eq("feed_addr", int'(bus.ab_addr), fc);
        for (int i = 0; i < DIM; i++) begin
          k  = fc - 1 - i;
          ea = (k >= 0 && k < DIM) ? a_m[i][k] : 0;
          eb = (k >= 0 && k < DIM) ? b_m[k][i] : 0;
          chk_eq($sformatf("skew_a%0d_c%0d", i, fc), int'($signed(sa_a[i])), ea);
          chk_eq($sformatf("skew_b%0d_c%0d", i, fc), int'($signed(sa_b[i])), eb);
        end
      end
      if (stalled) begin
        chk_eq("stall_valid", int'(bus.c_valid), 1);
        chk_eq("stall_row", int'(bus.c_row), int'(prow));
        chk_eq("stall_data_same", int'(bus.c_data == pdata), 1);
      end
      if (mode == 1) begin
        if (bus.c_valid && bus.c_row == 3 && st3 < 5) begin
          bus.c_ready = 1'b0;
          st3++;
        end else begin
          bus.c_ready = !bus.c_ready;
        end
      end
      if (bus.c_valid && bus.c_ready) begin
        chk_eq("row_order", int'(bus.c_row), nrow);
        if (chk_data)
          for (int j = 0; j < DIM; j++) begin
            lane = bus.c_data[j*BITS_C +: BITS_C];
            chk_eq($sformatf("c_r%0d_e%0d", nrow, j), int'(lane), use_sum ? (nrow + j) : exp_v);
          end
        nrow++;
      end
      stalled   = bus.c_valid && !bus.c_ready;
      prow      = bus.c_row;
      pdata     = bus.c_data;
      bus.start = poke && (cyc == 15 || cyc == 33);
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (done_cyc < 0) chk_eq("done_timeout", 0, 1);
    chk_eq("done_count", ndone, 1);
    chk_eq("rows_delivered", nrow, DIM);
    chk_eq("wren_cycles", nwr, acc_v ? 0 : DIM);
    chk_eq("en_cycles", nen, 3*DIM - 2);
    chk_eq("busy_after", int'(bus.busy), 0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.acc     = 1'b0;
    bus.c_ready = 1'b0;
    set_mats(0);
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", int'(bus.busy), 0);
    chk_eq("rst_done", int'(bus.done), 0);
    chk_eq("rst_ab_rd", int'(bus.ab_rd), 0);
    chk_eq("rst_ab_addr", int'(bus.ab_addr), 0);
    chk_eq("rst_sa_en", int'(sa_en), 0);
    chk_eq("rst_sa_wren", int'(sa_wren), 0);
    chk_eq("rst_sa_crow", int'(sa_crow), 0);
    chk_eq("rst_c_valid", int'(bus.c_valid), 0);
    chk_eq("rst_c_row", int'(bus.c_row), 0);
    chk_eq("rst_c_data_nz", int'(bus.c_data != '0), 0);
    chk_eq("rst_sa_a_nz", int'(sa_a != '0), 0);
    chk_eq("rst_sa_b_nz", int'(sa_b != '0), 0);
    chk_eq("rst_sa_cin_nz", int'(sa_cin != '0), 0);
    rst = 1'b0;

    set_mats(0); run_op(1'b0, 0, 1'b1, 1'b1, 0, 1'b0);
    set_mats(1); run_op(1'b0, 0, 1'b1, 1'b0, -48, 1'b0);
    run_op(1'b1, 0, 1'b1, 1'b0, -96, 1'b0);
    set_mats(2); run_op(1'b0, 0, 1'b1, 1'b0, 1024, 1'b0);
    set_mats(0); run_op(1'b0, 1, 1'b1, 1'b1, 0, 1'b0);
    run_op(1'b0, 0, 1'b1, 1'b1, 0, 1'b1);

    // Abort in the middle of FEED.
    @(negedge clk);
    bus.acc   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk_eq("pre_abort_en", int'(sa_en), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("abort_busy", int'(bus.busy), 0);
    chk_eq("abort_sa_en", int'(sa_en), 0);
    chk_eq("abort_ab_rd", int'(bus.ab_rd), 0);
    chk_eq("abort_sa_a_nz", int'(sa_a != '0), 0);
    chk_eq("abort_sa_b_nz", int'(sa_b != '0), 0);
    rst = 1'b0;

    // Start and reset together: reset wins.
    @(negedge clk);
    bus.start = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    chk_eq("start_rst_busy0", int'(bus.busy), 0);
    @(negedge clk);
    chk_eq("start_rst_busy1", int'(bus.busy), 0);
    chk_eq("start_rst_wren", int'(sa_wren), 0);

    set_mats(0); run_op(1'b0, 0, 1'b1, 1'b1, 0, 1'b0);
    set_mats(3); run_op(1'b1, 0, 1'b0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
